// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the memory responder.
// Little-endian lanes; sub-word loads are zero-extended.
package mem_pkg;

    typedef enum logic [1:0] {
        SzWord = 2'b00,
        SzHalf = 2'b01,
        SzByte = 2'b10
    } mem_size_t;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StRmwRd,
        StRmwWr,
        StResp
    } mem_state_t;

    // Replace the addressed lane(s) of old_word with right-aligned data.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input mem_size_t   size,
                                               input logic [1:0]  lane);
        logic [31:0] w;
        w = old_word;
        case (size)
            SzByte:  w[{lane, 3'b000} +: 8] = data[7:0];
            SzHalf:  w[{lane[1], 4'b0000} +: 16] = data[15:0];
            default: w = data;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input mem_size_t   size,
                                                 input logic [1:0]  lane);
        logic [31:0] r;
        case (size)
            SzByte:  r = {24'h0, word[{lane, 3'b000} +: 8]};
            SzHalf:  r = {16'h0, word[{lane[1], 4'b0000} +: 16]};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU memory port and the responder.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] address;
    logic [31:0] datain;
    logic        rsp_valid;
    logic [31:0] dataout;
    logic        addr_err;

    modport master (
        output req_valid, req_write, req_size, address, datain,
        input  req_ready, rsp_valid, dataout, addr_err
    );

    modport slave (
        input  req_valid, req_write, req_size, address, datain,
        output req_ready, rsp_valid, dataout, addr_err
    );
endinterface

// File: rtl/ram_sp.sv
// Single-port word-wide synchronous RAM: registered read, write-enable, no reset.
module ram_sp #(
    parameter int unsigned Depth = 64,
    parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, sub-word stores done as
// read-modify-write on a single-port array, one-cycle response pulse.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DepthWords = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    mem_responder_if.slave  bus
);

    localparam int unsigned AddrW     = (DepthWords > 1) ? $clog2(DepthWords) : 1;
    localparam logic [31:0] ByteLimit = 32'(4 * DepthWords);

    mem_state_t       state_q, state_d;
    logic [AddrW-1:0] word_q, word_d;
    logic [1:0]       lane_q, lane_d;
    mem_size_t        size_q, size_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             write_q, write_d;
    logic             err_q, err_d;
    logic [31:0]      dataout_q, dataout_d;

    mem_size_t        req_size;
    logic             misalign;
    logic             oob;
    logic             ram_we;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;
    logic [31:0]      load_data;
    logic             load_done;

    ram_sp #(
        .Depth (DepthWords),
        .AddrW (AddrW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (word_q),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Size 2'b11 is folded into a word access before any checks.
    always_comb begin
        req_size = (bus.req_size == 2'b11) ? SzWord : mem_size_t'(bus.req_size);
        misalign = ((req_size == SzHalf) && bus.address[0]) ||
                   ((req_size == SzWord) && (bus.address[1:0] != 2'b00));
        oob      = (bus.address >= ByteLimit);
    end

    assign load_data = lane_extract(ram_rdata, size_q, lane_q);
    assign ram_wdata = lane_merge(ram_rdata, wdata_q, size_q, lane_q);
    assign load_done = (state_q == StResp) && !write_q && !err_q;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        lane_d    = lane_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        err_d     = err_q;
        dataout_d = dataout_q;
        ram_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    word_d  = bus.address[AddrW+1:2];
                    lane_d  = bus.address[1:0];
                    size_d  = req_size;
                    wdata_d = bus.datain;
                    write_d = bus.req_write;
                    err_d   = misalign || oob;
                    if (misalign || oob) begin
                        state_d = StResp;
                    end else if (!bus.req_write) begin
                        state_d = StRd;
                    end else if (req_size == SzWord) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRd:    state_d = StResp;
            StWr: begin
                ram_we  = 1'b1;
                state_d = StResp;
            end
            StRmwRd: state_d = StRmwWr;
            StRmwWr: begin
                ram_we  = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                if (load_done) begin
                    dataout_d = load_data;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            word_q    <= '0;
            lane_q    <= 2'b00;
            size_q    <= SzWord;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            dataout_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            lane_q    <= lane_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            err_q     <= err_d;
            dataout_q <= dataout_d;
        end
    end

    // Load data is shown straight from the RAM during the response cycle, then held.
    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.dataout   = load_done ? load_data : dataout_q;
    assign bus.addr_err  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with hand-computed expectations.
module tb_mem_responder;

    localparam logic [1:0] W  = 2'b00;
    localparam logic [1:0] H  = 2'b01;
    localparam logic [1:0] B  = 2'b10;
    localparam logic [1:0] W3 = 2'b11;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mem_responder_if bus_if ();

    mem_responder #(
        .DepthWords (64)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tx(input string tag, input bit wr, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] data,
                      input int exp_lat, input logic [31:0] exp_dout, input bit exp_err);
        int          lat;
        logic [31:0] dout;
        logic        err;
        lat  = 0;
        dout = 32'hx;
        err  = 1'bx;
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = wr;
        bus_if.req_size  = sz;
        bus_if.address   = addr;
        bus_if.datain    = data;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus_if.rsp_valid) begin
                lat  = i;
                dout = bus_if.dataout;
                err  = bus_if.addr_err;
                break;
            end
        end
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".err"}, {31'h0, err}, {31'h0, exp_err});
        check({tag, ".dout"}, dout, exp_dout);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_size  = W;
        bus_if.address   = '0;
        bus_if.datain    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.ready", {31'h0, bus_if.req_ready}, 32'h1);
        check("rst.rsp", {31'h0, bus_if.rsp_valid}, 32'h0);
        check("rst.dout", bus_if.dataout, 32'h0);
        check("rst.err", {31'h0, bus_if.addr_err}, 32'h0);

        // Word store/load, byte merge, sub-word loads, size 11 as word
        tx("t1st",   1, W,  32'h10, 32'hDEADBEEF, 2, 32'h0, 0);
        tx("t1st0",  1, W,  32'h00, 32'h01020304, 2, 32'h0, 0);
        tx("t1ld",   0, W,  32'h10, 32'h0,        2, 32'hDEADBEEF, 0);
        tx("t2st",   1, B,  32'h11, 32'h000000AA, 3, 32'hDEADBEEF, 0);
        tx("t2ld",   0, W,  32'h10, 32'h0,        2, 32'hDEADAAEF, 0);
        tx("t3h",    0, H,  32'h12, 32'h0,        2, 32'h0000DEAD, 0);
        tx("t3b",    0, B,  32'h13, 32'h0,        2, 32'h000000DE, 0);
        tx("t3sz3",  0, W3, 32'h10, 32'h0,        2, 32'hDEADAAEF, 0);

        // Errors: misaligned and out of range, Dataout held
        tx("t4wmis", 0, W,  32'h13,  32'h0,        1, 32'hDEADAAEF, 1);
        tx("t4hmis", 1, H,  32'h11,  32'h0000FFFF, 1, 32'hDEADAAEF, 1);
        tx("t4oobw", 1, W,  32'h100, 32'hFFFFFFFF, 1, 32'hDEADAAEF, 1);
        tx("t4oobb", 0, B,  32'h103, 32'h0,        1, 32'hDEADAAEF, 1);
        tx("t4ld",   0, W,  32'h10,  32'h0,        2, 32'hDEADAAEF, 0);
        tx("t4ld0",  0, W,  32'h00,  32'h0,        2, 32'h01020304, 0);

        // Last legal byte and upper half-lane merge with junk upper data bits
        tx("edst",   1, W,  32'hFC, 32'h11223344, 2, 32'h01020304, 0);
        tx("edsb",   1, B,  32'hFF, 32'hFFFFFF77, 3, 32'h01020304, 0);
        tx("edlb",   0, B,  32'hFF, 32'h0,        2, 32'h00000077, 0);
        tx("edlw",   0, W,  32'hFC, 32'h0,        2, 32'h77223344, 0);
        tx("hst",    1, W,  32'h14, 32'hCAFEF00D, 2, 32'h77223344, 0);
        tx("hst2",   1, H,  32'h16, 32'h99991234, 3, 32'h77223344, 0);
        tx("hlw",    0, W,  32'h14, 32'h0,        2, 32'h1234F00D, 0);
        tx("hl0",    0, H,  32'h14, 32'h0,        2, 32'h0000F00D, 0);

        // Reset during RMW_WR drops the write and the response
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b1;
        bus_if.req_size  = H;
        bus_if.address   = 32'h10;
        bus_if.datain    = 32'h00001234;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("t5.rsp0", {31'h0, bus_if.rsp_valid}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5.rspr", {31'h0, bus_if.rsp_valid}, 32'h0);
        end
        rst_n = 1'b1;
        #1;
        check("t5.ready", {31'h0, bus_if.req_ready}, 32'h1);
        check("t5.dout", bus_if.dataout, 32'h0);
        tx("t5ld",   0, W,  32'h10, 32'h0, 2, 32'hDEADAAEF, 0);

        // Busy-time inputs are ignored
        tx("t6pre",  1, W,  32'h24, 32'h5A5A5A5A, 2, 32'hDEADAAEF, 0);
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b1;
        bus_if.req_size  = W;
        bus_if.address   = 32'h20;
        bus_if.datain    = 32'h11111111;
        @(posedge clk);
        #1;
        bus_if.address = 32'h24;
        bus_if.datain  = 32'h22222222;
        @(negedge clk);
        check("t6.rdy1", {31'h0, bus_if.req_ready}, 32'h0);
        check("t6.rsp1", {31'h0, bus_if.rsp_valid}, 32'h0);
        @(negedge clk);
        check("t6.rdy2", {31'h0, bus_if.req_ready}, 32'h0);
        check("t6.rsp2", {31'h0, bus_if.rsp_valid}, 32'h1);
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        check("t6.rdy3", {31'h0, bus_if.req_ready}, 32'h1);
        check("t6.rsp3", {31'h0, bus_if.rsp_valid}, 32'h0);
        tx("t6ld24", 0, W,  32'h24, 32'h0, 2, 32'h5A5A5A5A, 0);
        tx("t6ld20", 0, W,  32'h20, 32'h0, 2, 32'h11111111, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
